// File: rtl/sound_pkg.sv
// Shared sound-path definitions: envelope states, amplitude, phase and sample widths.
// Used by the tone synthesiser and the sound-event timer.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam int unsigned AMP_W    = 8;
  localparam int unsigned AMP_MAX  = 255;
  localparam int unsigned PHASE_W  = 24;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned FREQ_W   = 10;
  localparam int unsigned INC_W    = 20;

  // Phases at or above this value are in the negative half of the square period.
  localparam logic [PHASE_W-1:0] PHASE_HALF = {1'b1, {(PHASE_W-1){1'b0}}};

endpackage

// File: rtl/tone_phase_acc.sv
// 24-bit wrapping phase accumulator for the tone synthesiser.
// Ports: clk, resetN (sync, active-low), step_en (advance one sample),
//        clear (zero phase on a step), tone_freq (Hz),
//        phase_next (phase after this step, combinational), phase (registered).
module tone_phase_acc
  import sound_pkg::*;
#(
  parameter int unsigned INC_MULT = 350
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               step_en,
  input  logic               clear,
  input  logic [FREQ_W-1:0]  tone_freq,
  output logic [PHASE_W-1:0] phase_next,
  output logic [PHASE_W-1:0] phase
);

  logic [INC_W-1:0]   inc;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;

  // Per-sample increment, zero-extended into the accumulator width.
  assign inc        = INC_W'(tone_freq) * INC_W'(INC_MULT);
  assign phase_next = phase_q + PHASE_W'(inc);
  assign phase      = phase_q;

  always_comb begin
    phase_d = phase_q;
    if (step_en) begin
      phase_d = clear ? '0 : phase_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/tone_envelope_synth.sv
// Square-wave tone synthesiser with attack/sustain/release amplitude envelope.
// Ports: clk, resetN (sync, active-low), tone_en (tone request level),
//        tone_freq (Hz, 0 = silence), sample_req (codec strobe),
//        sample (signed output sample), sample_valid (one-cycle update pulse),
//        square_out (raw square for a buzzer), busy (envelope not idle).
module tone_envelope_synth
  import sound_pkg::*;
#(
  parameter int unsigned INC_MULT     = 350,
  parameter int unsigned ATTACK_STEP  = 32,
  parameter int unsigned RELEASE_STEP = 16
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       tone_en,
  input  logic [FREQ_W-1:0]          tone_freq,
  input  logic                       sample_req,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid,
  output logic                       square_out,
  output logic                       busy
);

  env_state_t          state_q, state_d;
  logic [AMP_W-1:0]    amp_q, amp_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                square_q, square_d;
  logic                busy_q, busy_d;

  logic [PHASE_W-1:0]  phase_next;
  logic [PHASE_W-1:0]  phase_cur;
  logic                phase_clear;

  logic [AMP_W:0]      amp_up9, amp_dn9;
  logic [AMP_W-1:0]    amp_up, amp_dn;
  logic [SAMPLE_W-1:0] mag;
  logic                do_attack, do_release;

  tone_phase_acc #(
    .INC_MULT (INC_MULT)
  ) u_phase (
    .clk        (clk),
    .resetN     (resetN),
    .step_en    (sample_req),
    .clear      (phase_clear),
    .tone_freq  (tone_freq),
    .phase_next (phase_next),
    .phase      (phase_cur)
  );

  // Saturating amplitude steps in 9 bits; a borrow into bit 8 means underflow.
  assign amp_up9 = {1'b0, amp_q} + (AMP_W+1)'(ATTACK_STEP);
  assign amp_dn9 = {1'b0, amp_q} - (AMP_W+1)'(RELEASE_STEP);
  assign amp_up  = (amp_up9 > (AMP_W+1)'(AMP_MAX)) ? AMP_W'(AMP_MAX) : amp_up9[AMP_W-1:0];
  assign amp_dn  = amp_dn9[AMP_W] ? '0 : amp_dn9[AMP_W-1:0];

  // Sustain holds while enabled; idle stays idle while disabled.
  assign do_attack  = tone_en && (state_q != SUSTAIN);
  assign do_release = !tone_en && (state_q != IDLE);

  // Phase restarts from zero whenever the envelope lands in IDLE.
  assign phase_clear = (state_d == IDLE);

  // Envelope next state, amplitude and sample formatting.
  always_comb begin
    state_d  = state_q;
    amp_d    = amp_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    mag      = '0;
    if (sample_req) begin
      if (do_attack) begin
        amp_d   = amp_up;
        state_d = (amp_up == AMP_W'(AMP_MAX)) ? SUSTAIN : ATTACK;
      end else if (do_release) begin
        amp_d   = amp_dn;
        state_d = (amp_dn == '0) ? IDLE : RELEASE;
      end
      mag      = SAMPLE_W'({amp_d, 7'b0});
      sample_d = (phase_next >= PHASE_HALF) ? (SAMPLE_W'(0) - mag) : mag;
      valid_d  = 1'b1;
    end
    busy_d   = (state_d != IDLE);
    square_d = busy_d && (sample_req ? (phase_next >= PHASE_HALF) : (phase_cur >= PHASE_HALF));
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= IDLE;
      amp_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      square_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      amp_q    <= amp_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      square_q <= square_d;
      busy_q   <= busy_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign square_out   = square_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_tone_envelope_synth.sv
// Self-checking bench for tone_envelope_synth: a behavioural envelope/phase model
// pushes the expected output for every request onto a scoreboard queue, and each
// scenario task pops and compares when sample_valid is due.
module tb_tone_envelope_synth;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               tone_en = 1'b0;
  logic [9:0]         tone_freq = '0;
  logic               sample_req = 1'b0;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               square_out;
  logic               busy;

  always #5 clk = ~clk;

  tone_envelope_synth dut (
    .clk          (clk),
    .resetN       (resetN),
    .tone_en      (tone_en),
    .tone_freq    (tone_freq),
    .sample_req   (sample_req),
    .sample       (sample),
    .sample_valid (sample_valid),
    .square_out   (square_out),
    .busy         (busy)
  );

  typedef struct {
    logic [15:0] smp;
    logic        sq;
    logic        bz;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model state: 0 idle, 1 attack, 2 sustain, 3 release.
  int m_st = 0;
  int m_amp = 0;
  int m_phase = 0;

  task automatic model_reset();
    m_st = 0; m_amp = 0; m_phase = 0;
    sb.delete();
  endtask

  // Drive one request (held until the caller changes it) and queue its expected result.
  task automatic push_req(input logic en, input int freq);
    int          pn;
    int          mag;
    logic [23:0] pv;
    exp_t        e;
    tone_en    = en;
    tone_freq  = 10'(freq);
    sample_req = 1'b1;
    pn = (m_phase + freq * 350) % (1 << 24);
    if (en && m_st != 2) begin
      m_amp = (m_amp + 32 > 255) ? 255 : m_amp + 32;
      m_st  = (m_amp == 255) ? 2 : 1;
    end else if (!en && m_st != 0) begin
      m_amp = (m_amp - 16 < 0) ? 0 : m_amp - 16;
      m_st  = (m_amp == 0) ? 0 : 3;
    end
    m_phase = (m_st == 0) ? 0 : pn;
    pv    = 24'(pn);
    mag   = m_amp * 128;
    e.smp = pv[23] ? 16'(-mag) : 16'(mag);
    e.sq  = (m_st != 0) ? pv[23] : 1'b0;
    e.bz  = (m_st != 0);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      resetN = 1'b0; sample_req = 1'b1; tone_en = 1'b1; tone_freq = 10'd480;
      @(negedge clk);
      n_tests++;
      if (sample !== 16'sd0 || sample_valid !== 1'b0 || square_out !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got s=%0d v=%b sq=%b busy=%b, want all 0", i, sample, sample_valid, square_out, busy);
      end
    end
    resetN = 1'b1; sample_req = 1'b0; tone_en = 1'b0;
    model_reset();
    @(negedge clk);
    n_tests++;
    if (sample !== 16'sd0 || sample_valid !== 1'b0 || square_out !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got s=%0d v=%b sq=%b busy=%b, want all 0", sample, sample_valid, square_out, busy);
    end
  endtask

  task automatic test_attack();
    exp_t e;
    logic signed [15:0] held;
    for (int i = 0; i < 8; i++) begin
      push_req(1'b1, 480);
      @(negedge clk);
      sample_req = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if (sample_valid !== 1'b1 || sample !== e.smp || square_out !== e.sq || busy !== e.bz) begin
        n_fail++;
        $display("FAIL attack[%0d]: got v=%b s=%0d sq=%b busy=%b, want v=1 s=%0d sq=%b busy=%b",
                 i, sample_valid, sample, square_out, busy, $signed(e.smp), e.sq, e.bz);
      end
      if (i == 0 || i == 7) begin
        n_tests++;
        if (sample !== ((i == 0) ? 16'sd4096 : 16'sd32640)) begin
          n_fail++;
          $display("FAIL attack_level[%0d]: got %0d, want %0d", i, sample, (i == 0) ? 4096 : 32640);
        end
      end
      held = sample;
      @(negedge clk);
      n_tests++;
      if (sample_valid !== 1'b0 || sample !== held) begin
        n_fail++;
        $display("FAIL attack_hold[%0d]: got v=%b s=%0d, want v=0 s=%0d", i, sample_valid, sample, held);
      end
    end
  endtask

  task automatic test_square();
    exp_t e;
    logic prev_sgn;
    int   last_flip;
    bit   have_flip;
    have_flip = 1'b0; last_flip = 0; prev_sgn = 1'b0;
    for (int i = 0; i < 200; i++) begin
      push_req(1'b1, 480);
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (sample_valid !== 1'b1 || sample !== e.smp || square_out !== e.sq || busy !== e.bz) begin
        n_fail++;
        $display("FAIL square[%0d]: got v=%b s=%0d sq=%b busy=%b, want v=1 s=%0d sq=%b busy=%b",
                 i, sample_valid, sample, square_out, busy, $signed(e.smp), e.sq, e.bz);
      end
      n_tests++;
      if ((sample !== 16'sd32640 && sample !== -16'sd32640) || square_out !== sample[15]) begin
        n_fail++;
        $display("FAIL square_level[%0d]: got s=%0d sq=%b, want |s|=32640 sq=sign", i, sample, square_out);
      end
      if (i > 0 && sample[15] !== prev_sgn) begin
        if (have_flip) begin
          n_tests++;
          if (i - last_flip < 49 || i - last_flip > 50) begin
            n_fail++;
            $display("FAIL square_halfperiod: got %0d requests, want 49..50", i - last_flip);
          end
        end
        have_flip = 1'b1; last_flip = i;
      end
      prev_sgn = sample[15];
    end
    sample_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_release();
    exp_t e;
    int   s, want;
    for (int i = 0; i < 16; i++) begin
      push_req(1'b0, 480);
      @(negedge clk);
      sample_req = 1'b0;
      e = sb.pop_front();
      s = int'(sample);
      want = 255 - 16 * (i + 1);
      if (want < 0) want = 0;
      n_tests++;
      if (sample_valid !== 1'b1 || sample !== e.smp || square_out !== e.sq || busy !== e.bz ||
          ((s < 0) ? -s : s) != want * 128) begin
        n_fail++;
        $display("FAIL release[%0d]: got v=%b s=%0d sq=%b busy=%b, want s=%0d |s|=%0d sq=%b busy=%b",
                 i, sample_valid, sample, square_out, busy, $signed(e.smp), want * 128, e.sq, e.bz);
      end
    end
    n_tests++;
    if (busy !== 1'b0 || sample !== 16'sd0 || square_out !== 1'b0) begin
      n_fail++;
      $display("FAIL release_idle: got busy=%b s=%0d sq=%b, want 0 0 0", busy, sample, square_out);
    end
  endtask

  task automatic test_retrigger();
    exp_t e;
    int   s;
    for (int i = 0; i < 17; i++) begin
      push_req((i < 8 || i == 16) ? 1'b1 : 1'b0, 480);
      @(negedge clk);
      sample_req = 1'b0;
      e = sb.pop_front();
      s = int'(sample);
      if (s < 0) s = -s;
      n_tests++;
      if (sample_valid !== 1'b1 || sample !== e.smp || square_out !== e.sq || busy !== e.bz) begin
        n_fail++;
        $display("FAIL retrigger[%0d]: got v=%b s=%0d sq=%b busy=%b, want v=1 s=%0d sq=%b busy=%b",
                 i, sample_valid, sample, square_out, busy, $signed(e.smp), e.sq, e.bz);
      end
      // First request from IDLE proves phase restarted at zero; then amp 127 and 159.
      if (i == 0 || i == 15 || i == 16) begin
        n_tests++;
        if (int'(sample) != ((i == 0) ? 4096 : 0) && i == 0 || i == 15 && s != 16256 || i == 16 && (s != 20352 || busy !== 1'b1)) begin
          n_fail++;
          $display("FAIL retrigger_level[%0d]: got s=%0d busy=%b", i, sample, busy);
        end
      end
    end
    for (int i = 0; i < 20; i++) begin
      push_req(1'b0, 480);
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (sample_valid !== 1'b1 || sample !== e.smp || square_out !== e.sq || busy !== e.bz) begin
        n_fail++;
        $display("FAIL retrigger_fade[%0d]: got s=%0d sq=%b busy=%b, want s=%0d sq=%b busy=%b",
                 i, sample, square_out, busy, $signed(e.smp), e.sq, e.bz);
      end
    end
    sample_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_freq0();
    exp_t e;
    int   want;
    for (int i = 0; i < 12; i++) begin
      push_req(1'b1, 0);
      @(negedge clk);
      e = sb.pop_front();
      want = (32 * (i + 1) > 255) ? 255 : 32 * (i + 1);
      n_tests++;
      if (sample_valid !== 1'b1 || sample !== e.smp || int'(sample) != want * 128 || square_out !== 1'b0) begin
        n_fail++;
        $display("FAIL freq0[%0d]: got s=%0d sq=%b, want s=%0d sq=0", i, sample, square_out, want * 128);
      end
    end
    for (int i = 0; i < 16; i++) begin
      push_req(1'b0, 0);
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (sample !== e.smp || busy !== e.bz || sample[15] !== 1'b0) begin
        n_fail++;
        $display("FAIL freq0_fade[%0d]: got s=%0d busy=%b, want s=%0d busy=%b", i, sample, busy, $signed(e.smp), e.bz);
      end
    end
    sample_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_freq_change();
    exp_t e;
    logic prev_sgn;
    int   last_flip;
    bit   have_flip;
    prev_sgn = 1'b0; last_flip = 0; have_flip = 1'b0;
    for (int i = 0; i < 200; i++) begin
      push_req(1'b1, (i < 100) ? 480 : 960);
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (sample_valid !== 1'b1 || sample !== e.smp || square_out !== e.sq || busy !== e.bz) begin
        n_fail++;
        $display("FAIL freq_change[%0d]: got s=%0d sq=%b busy=%b, want s=%0d sq=%b busy=%b",
                 i, sample, square_out, busy, $signed(e.smp), e.sq, e.bz);
      end
      if (i > 100 && sample[15] !== prev_sgn) begin
        if (have_flip) begin
          n_tests++;
          if (i - last_flip < 24 || i - last_flip > 25) begin
            n_fail++;
            $display("FAIL freq_change_halfperiod: got %0d requests, want 24..25", i - last_flip);
          end
        end
        have_flip = 1'b1; last_flip = i;
      end
      prev_sgn = sample[15];
    end
    sample_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      push_req(1'b1, 960);
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (sample_valid !== 1'b1 || sample !== e.smp || square_out !== e.sq) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got v=%b s=%0d sq=%b, want v=1 s=%0d sq=%b",
                 i, sample_valid, sample, square_out, $signed(e.smp), e.sq);
      end
    end
    sample_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (sample_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_end: got v=%b pending=%0d, want v=0 pending=0", sample_valid, sb.size());
    end
  endtask

  task automatic test_reset_mid_tone();
    exp_t e;
    resetN = 1'b0; sample_req = 1'b1; tone_en = 1'b1; tone_freq = 10'd960;
    @(negedge clk);
    n_tests++;
    if (sample !== 16'sd0 || sample_valid !== 1'b0 || square_out !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_tone: got s=%0d v=%b sq=%b busy=%b, want all 0", sample, sample_valid, square_out, busy);
    end
    resetN = 1'b1; sample_req = 1'b0;
    model_reset();
    @(negedge clk);
    push_req(1'b1, 480);
    @(negedge clk);
    sample_req = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (sample_valid !== 1'b1 || sample !== e.smp || sample !== 16'sd4096 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_restart: got v=%b s=%0d busy=%b, want v=1 s=4096 busy=1", sample_valid, sample, busy);
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_square();
    test_release();
    test_retrigger();
    test_freq0();
    test_freq_change();
    test_back_to_back();
    test_reset_mid_tone();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
